// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port word data memory between a CPU port (0) and a DMA port (1).
// Build option ARB_FIXED_PRIO_EN: port 0 wins ties instead of round-robin (burst limit still applies).
module dmem_arbiter #(
    parameter int DEPTH     = 64,
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wd0,
    input  logic [31:0] wd1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        err0,
    output logic        err1,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    // state | meaning
    // IDLE  | no access this cycle; burst run cleared
    // SERVE | winner registers drive the memory, gnt pulses for the winning port
    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    localparam logic [29:0] DEPTH_W   = 30'(DEPTH);
    localparam logic [3:0]  BURST_MAX = 4'(MAX_BURST);

    state_t      state_q, state_d;
    logic        gnt0_q, gnt0_d;
    logic        gnt1_q, gnt1_d;
    logic        err0_q, err0_d;
    logic        err1_q, err1_d;
    logic        rvalid0_q, rvalid0_d;
    logic        rvalid1_q, rvalid1_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic        acc_we_q, acc_we_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [31:0] mem_wd_q, mem_wd_d;
    logic        last_winner_q, last_winner_d;
    logic [3:0]  burst_q, burst_d;

    logic        any_req;
    logic        win_port;
    logic        win_we;
    logic [31:0] win_addr;
    logic [31:0] win_wd;
    logic        win_in_range;
    logic        win_bad;
    logic        cur_in_range;
    logic [31:0] rd_word;

    always_comb begin
        any_req = req0 | req1;

        // burst_q always counts grants to last_winner, so hitting the limit hands the tie to the other port
        if (req0 && req1) begin
            if (burst_q >= BURST_MAX) begin
                win_port = ~last_winner_q;
            end else begin
`ifdef ARB_FIXED_PRIO_EN
                win_port = 1'b0;
`else
                win_port = ~last_winner_q;
`endif
            end
        end else begin
            win_port = req1;
        end

        win_we       = win_port ? we1   : we0;
        win_addr     = win_port ? addr1 : addr0;
        win_wd       = win_port ? wd1   : wd0;
        win_in_range = win_addr[31:2] < DEPTH_W;
        win_bad      = ~win_in_range | (win_addr[1:0] != 2'b00);

        cur_in_range = mem_a_q[31:2] < DEPTH_W;
        rd_word      = cur_in_range ? mem_rd : 32'd0;

        state_d       = any_req ? SERVE : IDLE;
        gnt0_d        = any_req & ~win_port;
        gnt1_d        = any_req & win_port;
        err0_d        = gnt0_d & win_bad;
        err1_d        = gnt1_d & win_bad;
        acc_we_d      = any_req & win_we;
        mem_a_d       = any_req ? {win_addr[31:2], 2'b00} : mem_a_q;
        mem_wd_d      = any_req ? win_wd : mem_wd_q;
        last_winner_d = any_req ? win_port : last_winner_q;

        if (!any_req) begin
            burst_d = 4'd0;
        end else if (win_port == last_winner_q) begin
            burst_d = (burst_q == 4'hF) ? burst_q : burst_q + 4'd1;
        end else begin
            burst_d = 4'd1;
        end

        // read data is taken from the memory at the end of the SERVE cycle
        rvalid0_d = (state_q == SERVE) & gnt0_q & ~acc_we_q;
        rvalid1_d = (state_q == SERVE) & gnt1_q & ~acc_we_q;
        rdata0_d  = rvalid0_d ? rd_word : rdata0_q;
        rdata1_d  = rvalid1_d ? rd_word : rdata1_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            err0_q        <= 1'b0;
            err1_q        <= 1'b0;
            rvalid0_q     <= 1'b0;
            rvalid1_q     <= 1'b0;
            rdata0_q      <= 32'd0;
            rdata1_q      <= 32'd0;
            acc_we_q      <= 1'b0;
            mem_a_q       <= 32'd0;
            mem_wd_q      <= 32'd0;
            last_winner_q <= 1'b1;
            burst_q       <= 4'd0;
        end else begin
            state_q       <= state_d;
            gnt0_q        <= gnt0_d;
            gnt1_q        <= gnt1_d;
            err0_q        <= err0_d;
            err1_q        <= err1_d;
            rvalid0_q     <= rvalid0_d;
            rvalid1_q     <= rvalid1_d;
            rdata0_q      <= rdata0_d;
            rdata1_q      <= rdata1_d;
            acc_we_q      <= acc_we_d;
            mem_a_q       <= mem_a_d;
            mem_wd_q      <= mem_wd_d;
            last_winner_q <= last_winner_d;
            burst_q       <= burst_d;
        end
    end

    assign mem_we  = (state_q == SERVE) & acc_we_q & cur_in_range;
    assign mem_a   = mem_a_q;
    assign mem_wd  = mem_wd_q;
    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign err0    = err0_q;
    assign err1    = err1_q;
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a 64-word memory model.
// Expected arbitration follows ARB_FIXED_PRIO_EN when the build defines it.
module tb_dmem_arbiter;

    localparam int MB = 2;
`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wd0, wd1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_we;
    logic [31:0] rdata0, rdata1, mem_a, mem_wd, mem_rd;

    logic [31:0] ram [64];
    logic        ram_init;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DEPTH(64), .MAX_BURST(MB)) u_dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wd0(wd0), .wd1(wd1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    function automatic logic [31:0] init_word(int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    // out-of-range words return junk so the arbiter must supply the zero itself
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
        end else if (mem_we) begin
            ram[mem_a[7:2]] <= mem_wd;
        end
    end
    assign mem_rd = (mem_a[31:8] == 24'd0) ? ram[mem_a[7:2]] : 32'hBADC_0DE5;

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if ({gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_we} !== 7'b0) begin
            bad++; $display("FAIL reset_ctl got=%b exp=0", {gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_we}); end
        total++; if ({mem_a, mem_wd, rdata0, rdata1} !== 128'd0) begin
            bad++; $display("FAIL reset_data got=%h exp=0", {mem_a, mem_wd, rdata0, rdata1}); end
        reset = 1'b0; ram_init = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10; wd0 = 32'hCAFE_F00D;
        @(posedge clk); #2;
        total++; if (gnt0 !== 1'b1 || mem_a !== 32'h10) begin
            bad++; $display("FAIL reset_pre_serve got=%b/%h exp=1/10", gnt0, mem_a); end
        reset = 1'b1; #1;
        total++; if ({gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_we} !== 7'b0) begin
            bad++; $display("FAIL reset_mid_ctl got=%b exp=0", {gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_we}); end
        total++; if ({mem_a, mem_wd, rdata0} !== 96'd0) begin
            bad++; $display("FAIL reset_mid_data got=%h exp=0", {mem_a, mem_wd, rdata0}); end
        req0 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b0) begin
                bad++; $display("FAIL reset_after got=%b exp=0", {gnt0, gnt1, rvalid0, rvalid1}); end
        end
    endtask

    task automatic test_idle();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++; if ({gnt0, gnt1, mem_we, err0, err1} !== 5'b0) begin
                bad++; $display("FAIL idle c=%0d got=%b exp=0", c, {gnt0, gnt1, mem_we, err0, err1}); end
        end
    endtask

    task automatic test_single_rw();
        we0 = 1'b1; addr0 = 32'h10; wd0 = 32'hDEAD_BEEF; req0 = 1'b1;
        @(negedge clk);
        total++; if ({gnt0, gnt1, mem_we, err0} !== 4'b1010) begin
            bad++; $display("FAIL rw_wr_ctl got=%b exp=1010", {gnt0, gnt1, mem_we, err0}); end
        total++; if (mem_a !== 32'h10 || mem_wd !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL rw_wr_bus got=%h/%h exp=10/deadbeef", mem_a, mem_wd); end
        req0 = 1'b0;
        @(negedge clk);
        total++; if ({gnt0, mem_we, rvalid0} !== 3'b0) begin
            bad++; $display("FAIL rw_wr_after got=%b exp=0", {gnt0, mem_we, rvalid0}); end
        we0 = 1'b0; req0 = 1'b1;
        @(negedge clk);
        total++; if ({gnt0, mem_we, rvalid0} !== 3'b100) begin
            bad++; $display("FAIL rw_rd_gnt got=%b exp=100", {gnt0, mem_we, rvalid0}); end
        req0 = 1'b0;
        @(negedge clk);
        total++; if (rvalid0 !== 1'b1 || rdata0 !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL rw_rd_data got=%b/%h exp=1/deadbeef", rvalid0, rdata0); end
        @(negedge clk);
        total++; if (rvalid0 !== 1'b0 || rdata0 !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL rw_rd_hold got=%b/%h exp=0/deadbeef", rvalid0, rdata0); end
    endtask

    task automatic test_range();
        we1 = 1'b1; addr1 = 32'h100; wd1 = 32'h5555_5555; req1 = 1'b1;
        @(negedge clk);
        total++; if ({gnt1, err1, mem_we, gnt0, err0} !== 5'b11000 || mem_a !== 32'h100) begin
            bad++; $display("FAIL range_wr got=%b/%h exp=11000/100", {gnt1, err1, mem_we, gnt0, err0}, mem_a); end
        we1 = 1'b0;
        @(negedge clk);
        total++; if ({gnt1, err1} !== 2'b11) begin
            bad++; $display("FAIL range_rd_gnt got=%b exp=11", {gnt1, err1}); end
        req1 = 1'b0;
        @(negedge clk);
        total++; if (rvalid1 !== 1'b1 || rdata1 !== 32'd0) begin
            bad++; $display("FAIL range_rd_data got=%b/%h exp=1/0", rvalid1, rdata1); end
        we0 = 1'b1; addr0 = 32'h13; wd0 = 32'h1234_5678; req0 = 1'b1;
        @(negedge clk);
        total++; if ({gnt0, err0, mem_we} !== 3'b111 || mem_a !== 32'h10) begin
            bad++; $display("FAIL misal_wr got=%b/%h exp=111/10", {gnt0, err0, mem_we}, mem_a); end
        we0 = 1'b0; addr0 = 32'h10;
        @(negedge clk);
        total++; if ({gnt0, err0} !== 2'b10) begin
            bad++; $display("FAIL misal_rd_gnt got=%b exp=10", {gnt0, err0}); end
        req0 = 1'b0;
        @(negedge clk);
        total++; if (rvalid0 !== 1'b1 || rdata0 !== 32'h1234_5678) begin
            bad++; $display("FAIL misal_rd_data got=%b/%h exp=1/12345678", rvalid0, rdata0); end
    endtask

    task automatic test_contention();
        logic p1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        we0 = 1'b0; addr0 = 32'h0; we1 = 1'b0; addr1 = 32'h4;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            p1 = FIXED ? ((k % (MB + 1)) == MB) : ((k % 2) == 1);
            total++; if ({gnt1, gnt0} !== (p1 ? 2'b10 : 2'b01)) begin
                bad++; $display("FAIL contention k=%0d got=%b exp=%b", k, {gnt1, gnt0}, p1 ? 2'b10 : 2'b01); end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_burst();
        int  lost;
        bit  got;
        we0 = 1'b0; addr0 = 32'h0; req0 = 1'b1;
        for (int n = 0; n < 4; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            we1 = 1'b0; addr1 = 32'h8; req1 = 1'b1;
            lost = 0; got = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                @(negedge clk);
                total++; if (gnt0 === 1'b1 && gnt1 === 1'b1) begin
                    bad++; $display("FAIL burst_both got=11 exp=one-hot"); end
                if (gnt1 === 1'b1) got = 1'b1;
                else if (gnt0 === 1'b1) lost++;
            end
            req1 = 1'b0;
            total++; if (!got || lost > MB) begin
                bad++; $display("FAIL burst_wait n=%0d got=%0d/%0b exp<=%0d/1", n, lost, got, MB); end
        end
        req0 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] ref_mem [64];
        logic        pend [2];
        logic        t_we [2];
        logic [31:0] t_addr [2];
        logic [31:0] t_wd [2];
        logic        s_req [2];
        logic        exp_rv [2];
        logic [31:0] exp_rd [2];
        logic        nrv [2];
        logic [31:0] nrd [2];
        int          wait_cnt [2];
        int          run, r;
        logic        last, gv, wp, inr, bad_acc;
        logic [31:0] a;
        logic [1:0]  exp_g, exp_e;

        @(negedge clk);
        reset = 1'b1; ram_init = 1'b1; req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        reset = 1'b0; ram_init = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; s_req[p] = 1'b0; exp_rv[p] = 1'b0; exp_rd[p] = 32'd0;
            t_we[p] = 1'b0; t_addr[p] = 32'd0; t_wd[p] = 32'd0; wait_cnt[p] = 0;
        end
        last = 1'b1; run = 0;

        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            gv = s_req[0] | s_req[1];
            if (s_req[0] && s_req[1]) wp = (run >= MB) ? ~last : (FIXED ? 1'b0 : ~last);
            else wp = s_req[1];
            exp_g = gv ? (wp ? 2'b10 : 2'b01) : 2'b00;
            total++; if ({gnt1, gnt0} !== exp_g) begin
                bad++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, {gnt1, gnt0}, exp_g); end
            for (int p = 0; p < 2; p++) begin nrv[p] = 1'b0; nrd[p] = exp_rd[p]; end
            exp_e = 2'b00;
            if (gv) begin
                a = t_addr[wp];
                inr = (a[31:2] < 30'd64);
                bad_acc = !inr || (a[1:0] != 2'b00);
                exp_e = wp ? {bad_acc, 1'b0} : {1'b0, bad_acc};
                total++; if (mem_a !== {a[31:2], 2'b00} || mem_we !== (t_we[wp] & inr)) begin
                    bad++; $display("FAIL rnd_bus c=%0d got=%h/%b exp=%h/%b", c, mem_a, mem_we, {a[31:2], 2'b00}, t_we[wp] & inr); end
                if (t_we[wp]) begin
                    total++; if (mem_wd !== t_wd[wp]) begin
                        bad++; $display("FAIL rnd_wd c=%0d got=%h exp=%h", c, mem_wd, t_wd[wp]); end
                end
                total++; if (wait_cnt[wp] > MB) begin
                    bad++; $display("FAIL rnd_wait c=%0d got=%0d exp<=%0d", c, wait_cnt[wp], MB); end
                if (t_we[wp] && inr) ref_mem[a[7:2]] = t_wd[wp];
                if (!t_we[wp]) begin nrv[wp] = 1'b1; nrd[wp] = inr ? ref_mem[a[7:2]] : 32'd0; end
                pend[wp] = 1'b0; wait_cnt[wp] = 0;
                run = (wp == last) ? run + 1 : 1;
                last = wp;
            end else begin
                run = 0;
                total++; if (mem_we !== 1'b0) begin
                    bad++; $display("FAIL rnd_idle_we c=%0d got=%b exp=0", c, mem_we); end
            end
            total++; if ({err1, err0} !== exp_e) begin
                bad++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, {err1, err0}, exp_e); end
            total++; if ({rvalid1, rvalid0} !== {exp_rv[1], exp_rv[0]}) begin
                bad++; $display("FAIL rnd_rvalid c=%0d got=%b exp=%b", c, {rvalid1, rvalid0}, {exp_rv[1], exp_rv[0]}); end
            if (exp_rv[0]) begin
                total++; if (rdata0 !== exp_rd[0]) begin
                    bad++; $display("FAIL rnd_rdata0 c=%0d got=%h exp=%h", c, rdata0, exp_rd[0]); end
            end
            if (exp_rv[1]) begin
                total++; if (rdata1 !== exp_rd[1]) begin
                    bad++; $display("FAIL rnd_rdata1 c=%0d got=%h exp=%h", c, rdata1, exp_rd[1]); end
            end
            for (int p = 0; p < 2; p++) begin
                if (s_req[p] && !(gv && wp == p[0])) wait_cnt[p]++;
                exp_rv[p] = nrv[p]; exp_rd[p] = nrd[p];
                if (!pend[p] && $urandom_range(0, 99) < 55) begin
                    pend[p] = 1'b1;
                    t_we[p] = ($urandom_range(0, 1) == 1);
                    t_wd[p] = $urandom;
                    r = $urandom_range(0, 9);
                    if (r == 0)      t_addr[p] = 32'h100 + ($urandom_range(0, 31) << 2);
                    else if (r == 1) t_addr[p] = ($urandom_range(0, 15) << 2) | $urandom_range(1, 3);
                    else if (r == 2) t_addr[p] = 32'hFFFF_FFF0 | ($urandom_range(0, 3) << 2);
                    else             t_addr[p] = $urandom_range(0, 15) << 2;
                end
                s_req[p] = pend[p];
            end
            req0 = pend[0]; we0 = t_we[0]; addr0 = t_addr[0]; wd0 = t_wd[0];
            req1 = pend[1]; we1 = t_we[1]; addr1 = t_addr[1]; wd1 = t_wd[1];
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; ram_init = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 32'd0; addr1 = 32'd0; wd0 = 32'd0; wd1 = 32'd0;
        test_reset();
        test_idle();
        test_single_rw();
        test_range();
        test_contention();
        test_burst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
